// File: rtl/lsu_mem_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_mem_ctrl
//
// Load/store controller sitting directly in front of data_memory. Converts
// byte-addressed load/store requests from the datapath into word-indexed
// memory accesses. Byte, halfword and word sizes are supported. Sub-word
// stores are done as read-modify-write. Loads are sign- or zero-extended.
//
// Build option:
//   MISALIGN_TRAP_EN  defined   : misaligned half/word requests are answered
//                                 with resp_err=1 and no memory access.
//                     undefined : misaligned addresses are aligned down and the
//                                 access proceeds; resp_err is tied 0.
//
// Parameters:
//   MEM_AW          word-index width of data_memory (2^MEM_AW words)
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   req_valid       request present, held with req_* stable until accepted
//   req_ready       controller idle; request accepted this cycle if req_valid
//   req_write       1 = store, 0 = load
//   req_size        00 byte, 01 half, 10/11 word
//   req_unsigned    loads only: zero-extend instead of sign-extend
//   req_addr        byte address
//   req_wdata       store data, low bits used for sub-word stores
//   resp_valid      one-cycle pulse, access complete
//   resp_rdata      extended load data, 0 for stores and errors
//   resp_err        misaligned access (trap build only)
//   mem_address     word index {zeros, addr[MEM_AW+1:2]} while accessing
//   mem_write_data  merged store word during the write cycle
//   mem_read_data   combinational read data from memory
//   sig_memread     read strobe
//   sig_memwrite    write strobe
//   dbg_state       current FSM state (IDLE=0, RD=1, WR=2, RESP=3)
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1. req_ready is 1 only in IDLE, so at most one request is
// in flight; the requester keeps req_valid and req_* stable until that edge.
// Completion is a single-cycle resp_valid pulse; there is no back-pressure on
// the response side.
// ---------------------------------------------------------------------------
module lsu_mem_ctrl #(
    parameter int MEM_AW = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    output logic        sig_memread,
    output logic        sig_memwrite,
    output logic [1:0]  dbg_state
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    // ------------------------------------------------------------------
    // State and latched request fields
    // ------------------------------------------------------------------
    logic [1:0]        state_q, state_d;
    logic              write_q, write_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [MEM_AW-1:0] index_q, index_d;
    logic [1:0]        lane_q, lane_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       data_q, data_d;
    logic              err_q, err_d;

    logic              misalign;
    logic [1:0]        req_lane;
    logic [31:0]       merged_word;
    logic [31:0]       load_word;
    logic [7:0]        load_byte;
    logic [15:0]       load_half;
    logic              in_access;

    // Address bits above the word index are deliberately ignored so that
    // out-of-range addresses wrap onto the memory.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:MEM_AW+2];

    // ------------------------------------------------------------------
    // Alignment handling on the incoming request
    // ------------------------------------------------------------------
`ifdef MISALIGN_TRAP_EN
    assign misalign = ((req_size == 2'b01) && req_addr[0]) ||
                      (req_size[1] && (req_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    // Lane within the word. Halves and words are aligned down; in the trap
    // build a misaligned request never reaches RD/WR, so this is harmless.
    always_comb begin
        case (req_size)
            2'b00:   req_lane = req_addr[1:0];
            2'b01:   req_lane = {req_addr[1], 1'b0};
            default: req_lane = 2'b00;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        write_d = write_q;
        size_d  = size_q;
        uns_d   = uns_q;
        index_d = index_q;
        lane_d  = lane_q;
        wdata_d = wdata_q;
        data_d  = data_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    index_d = req_addr[MEM_AW+1:2];
                    lane_d  = req_lane;
                    wdata_d = req_wdata;
                    err_d   = misalign;
                    if (misalign) begin
                        state_d = ST_RESP;
                    end else if (req_write && req_size[1]) begin
                        // Full-word store needs no read of the old word.
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: begin
                data_d  = mem_read_data;
                state_d = write_q ? ST_WR : ST_RESP;
            end
            ST_WR: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            write_q <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            index_q <= '0;
            lane_q  <= 2'b00;
            wdata_q <= 32'h0;
            data_q  <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            index_q <= index_d;
            lane_q  <= lane_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Store merge: old word from data_q with the addressed lane replaced.
    // ------------------------------------------------------------------
    always_comb begin
        merged_word = data_q;
        case (size_q)
            2'b00: begin
                case (lane_q)
                    2'd0:    merged_word[7:0]   = wdata_q[7:0];
                    2'd1:    merged_word[15:8]  = wdata_q[7:0];
                    2'd2:    merged_word[23:16] = wdata_q[7:0];
                    default: merged_word[31:24] = wdata_q[7:0];
                endcase
            end
            2'b01: begin
                if (lane_q[1]) begin
                    merged_word[31:16] = wdata_q[15:0];
                end else begin
                    merged_word[15:0] = wdata_q[15:0];
                end
            end
            default: begin
                merged_word = wdata_q;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Load extraction, little-endian, with sign/zero extension.
    // ------------------------------------------------------------------
    always_comb begin
        case (lane_q)
            2'd0:    load_byte = data_q[7:0];
            2'd1:    load_byte = data_q[15:8];
            2'd2:    load_byte = data_q[23:16];
            default: load_byte = data_q[31:24];
        endcase

        load_half = lane_q[1] ? data_q[31:16] : data_q[15:0];

        case (size_q)
            2'b00: begin
                load_word = uns_q ? {24'h0, load_byte}
                                  : {{24{load_byte[7]}}, load_byte};
            end
            2'b01: begin
                load_word = uns_q ? {16'h0, load_half}
                                  : {{16{load_half[15]}}, load_half};
            end
            default: begin
                load_word = data_q;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from state and latched registers only, so nothing on
    // req_* reaches the memory side combinationally, and everything is
    // forced to zero whenever the FSM sits in IDLE.
    // ------------------------------------------------------------------
    assign in_access      = (state_q == ST_RD) || (state_q == ST_WR);

    assign req_ready      = (state_q == ST_IDLE);
    assign sig_memread    = (state_q == ST_RD);
    assign sig_memwrite   = (state_q == ST_WR);
    assign mem_address    = in_access ? {{(32-MEM_AW){1'b0}}, index_q} : 32'h0;
    assign mem_write_data = (state_q == ST_WR) ? merged_word : 32'h0;
    assign resp_valid     = (state_q == ST_RESP);
    assign resp_rdata     = ((state_q == ST_RESP) && !write_q && !err_q) ? load_word : 32'h0;
    assign dbg_state      = state_q;

`ifdef MISALIGN_TRAP_EN
    assign resp_err       = (state_q == ST_RESP) && err_q;
`else
    assign resp_err       = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lsu_mem_ctrl
//
// Bench for lsu_mem_ctrl with a 32-word memory model preloaded mem[i]=i.
// A table of directed vectors is applied first, followed by random requests
// whose expectations come from a small reference model, then two hand-written
// sequences: reset during the read phase of a byte store, and a request held
// valid across its whole transaction. Responses are matched against an
// expected queue when resp_valid pulses.
// ---------------------------------------------------------------------------
module tb_lsu_mem_ctrl;

  localparam int MEM_AW = 5;
  localparam int NWORDS = 32;
  localparam int NTBL   = 21;
  localparam int NRAND  = 40;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
    logic [31:0] exp_idx;
    logic [31:0] exp_wdata;
  } vec_t;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        sig_memread;
  logic        sig_memwrite;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.MEM_AW(MEM_AW)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_size       (req_size),
    .req_unsigned   (req_unsigned),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .sig_memread    (sig_memread),
    .sig_memwrite   (sig_memwrite),
    .dbg_state      (dbg_state)
  );

  // ---------------- memory model ----------------
  logic [31:0] mem     [NWORDS];
  logic [31:0] ref_mem [NWORDS];

  assign mem_read_data = mem[mem_address[4:0]];

  always @(posedge clk) begin
    if (sig_memwrite) mem[mem_address[4:0]] <= mem_write_data;
  end

  // ---------------- scoreboard ----------------
  int          n_vec = 0;
  int          n_err = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          resp_cnt = 0;
  int          acc_cnt = 0;
  logic [31:0] last_rd_idx = 32'h0;
  logic [31:0] last_wr_idx = 32'h0;
  logic [31:0] last_wdata = 32'h0;
  logic [32:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Strobe/response monitor, sampled on the falling edge.
  always @(negedge clk) begin : mon
    logic [32:0] e;
    if (sig_memread) begin
      rd_cnt++;
      last_rd_idx = mem_address;
    end
    if (sig_memwrite) begin
      wr_cnt++;
      last_wr_idx = mem_address;
      last_wdata  = mem_write_data;
    end
    if (resp_valid) begin
      resp_cnt++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL resp_unexpected: got resp_valid=1 rdata=0x%08h, expected no response", resp_rdata);
      end else begin
        e = exp_q.pop_front();
        chk("resp_rdata", resp_rdata, e[31:0]);
        chk("resp_err", 32'(resp_err), 32'(e[32]));
      end
    end
  end

  // Accepts counted at the active edge, before the DUT state moves.
  always @(posedge clk) begin
    if (!reset && req_valid && req_ready) acc_cnt++;
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] size,
                                             input logic uns, input logic [31:0] addr);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> (8 * int'(addr[1:0])));
    h = addr[1] ? w[31:16] : w[15:0];
    case (size)
      2'b00:   return uns ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   return uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] model_merge(input logic [31:0] w, input logic [1:0] size,
                                              input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] r;
    r = w;
    case (size)
      2'b00:   r[8*int'(addr[1:0]) +: 8] = wd[7:0];
      2'b01:   r[16*int'(addr[1]) +: 16] = wd[15:0];
      default: r = wd;
    endcase
    return r;
  endfunction

  function automatic vec_t mk(input logic wr, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input logic exp_err,
                              input int exp_lat, input int exp_rd, input int exp_wr,
                              input logic [31:0] exp_idx, input logic [31:0] exp_wdata);
    vec_t v;
    v.wr = wr; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
    v.exp_rd = exp_rd; v.exp_wr = exp_wr; v.exp_idx = exp_idx; v.exp_wdata = exp_wdata;
    return v;
  endfunction

  // ---------------- driver ----------------
  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    @(negedge clk);
    req_write    = v.wr;
    req_size     = v.size;
    req_unsigned = v.uns;
    req_addr     = v.addr;
    req_wdata    = v.wdata;
    req_valid    = 1'b1;
    lat = 0;
    while (!req_ready && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    rd_cnt = 0;
    wr_cnt = 0;
    exp_q.push_back({v.exp_err, v.exp_rdata});
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    if (!resp_valid) exp_q.delete();
    chk({tag, "_latency"}, 32'(lat), 32'(v.exp_lat));
    chk({tag, "_rd_strobes"}, 32'(rd_cnt), 32'(v.exp_rd));
    chk({tag, "_wr_strobes"}, 32'(wr_cnt), 32'(v.exp_wr));
    if (v.exp_rd > 0) chk({tag, "_rd_index"}, last_rd_idx, v.exp_idx);
    if (v.exp_wr > 0) begin
      chk({tag, "_wr_index"}, last_wr_idx, v.exp_idx);
      chk({tag, "_wr_data"}, last_wdata, v.exp_wdata);
      ref_mem[v.exp_idx[4:0]] = v.exp_wdata;
    end
    @(negedge clk);
    chk({tag, "_idle_ctl"}, {28'h0, req_ready, sig_memread, sig_memwrite, resp_valid}, 32'h8);
    chk({tag, "_idle_addr"}, mem_address, 32'h0);
    chk({tag, "_idle_wdata"}, mem_write_data, 32'h0);
  endtask

  // ---------------- stimulus ----------------
  vec_t        tbl [NTBL];
  vec_t        rv;
  logic [31:0] ra;
  logic [31:0] old_w;
  logic        sub;
  int          resp_before;
  int          lat_b;

  initial begin
    reset        = 1'b1;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    for (int i = 0; i < NWORDS; i++) begin
      mem[i]     = 32'(i);
      ref_mem[i] = 32'(i);
    end

    //             wr sz    u  addr        wdata         rdata         err lat rd wr idx  wdata_exp
    tbl[0]  = mk(0, 2'd2, 0, 32'h14,     32'h0,        32'h00000005, 0, 2, 1, 0, 5,  32'h0);
    tbl[1]  = mk(1, 2'd0, 0, 32'h09,     32'h80,       32'h0,        0, 3, 1, 1, 2,  32'h00008002);
    tbl[2]  = mk(0, 2'd0, 0, 32'h09,     32'h0,        32'hFFFFFF80, 0, 2, 1, 0, 2,  32'h0);
    tbl[3]  = mk(0, 2'd0, 1, 32'h09,     32'h0,        32'h00000080, 0, 2, 1, 0, 2,  32'h0);
    tbl[4]  = mk(1, 2'd1, 0, 32'h0E,     32'hBEEF,     32'h0,        0, 3, 1, 1, 3,  32'hBEEF0003);
    tbl[5]  = mk(0, 2'd1, 0, 32'h0E,     32'h0,        32'hFFFFBEEF, 0, 2, 1, 0, 3,  32'h0);
    tbl[6]  = mk(0, 2'd1, 1, 32'h0E,     32'h0,        32'h0000BEEF, 0, 2, 1, 0, 3,  32'h0);
    tbl[7]  = mk(1, 2'd2, 0, 32'h1C,     32'hDEADBEEF, 32'h0,        0, 2, 0, 1, 7,  32'hDEADBEEF);
    tbl[8]  = mk(0, 2'd2, 0, 32'h1C,     32'h0,        32'hDEADBEEF, 0, 2, 1, 0, 7,  32'h0);
    tbl[9]  = mk(0, 2'd2, 0, 32'h9C,     32'h0,        32'hDEADBEEF, 0, 2, 1, 0, 7,  32'h0);
    tbl[10] = mk(1, 2'd0, 0, 32'h13,     32'hFFFFFF12, 32'h0,        0, 3, 1, 1, 4,  32'h12000004);
    tbl[11] = mk(0, 2'd3, 0, 32'h10,     32'h0,        32'h12000004, 0, 2, 1, 0, 4,  32'h0);
    tbl[12] = mk(0, 2'd0, 0, 32'h13,     32'h0,        32'h00000012, 0, 2, 1, 0, 4,  32'h0);
    tbl[13] = mk(0, 2'd1, 0, 32'h12,     32'h0,        32'h00001200, 0, 2, 1, 0, 4,  32'h0);
    tbl[14] = mk(1, 2'd0, 0, 32'h00,     32'h7F,       32'h0,        0, 3, 1, 1, 0,  32'h0000007F);
    tbl[15] = mk(0, 2'd2, 1, 32'h00,     32'h0,        32'h0000007F, 0, 2, 1, 0, 0,  32'h0);
`ifdef MISALIGN_TRAP_EN
    tbl[16] = mk(0, 2'd2, 0, 32'h06,     32'h0,        32'h0,        1, 1, 0, 0, 0,  32'h0);
    tbl[17] = mk(1, 2'd1, 0, 32'h0F,     32'h1234,     32'h0,        1, 1, 0, 0, 0,  32'h0);
    tbl[18] = mk(0, 2'd1, 1, 32'h0E,     32'h0,        32'h0000BEEF, 0, 2, 1, 0, 3,  32'h0);
    tbl[19] = mk(1, 2'd2, 0, 32'h21,     32'hCAFEF00D, 32'h0,        1, 1, 0, 0, 0,  32'h0);
    tbl[20] = mk(0, 2'd2, 0, 32'h20,     32'h0,        32'h00000008, 0, 2, 1, 0, 8,  32'h0);
`else
    tbl[16] = mk(0, 2'd2, 0, 32'h06,     32'h0,        32'h00000001, 0, 2, 1, 0, 1,  32'h0);
    tbl[17] = mk(1, 2'd1, 0, 32'h0F,     32'h1234,     32'h0,        0, 3, 1, 1, 3,  32'h12340003);
    tbl[18] = mk(0, 2'd1, 1, 32'h0E,     32'h0,        32'h00001234, 0, 2, 1, 0, 3,  32'h0);
    tbl[19] = mk(1, 2'd2, 0, 32'h21,     32'hCAFEF00D, 32'h0,        0, 2, 0, 1, 8,  32'hCAFEF00D);
    tbl[20] = mk(0, 2'd2, 0, 32'h20,     32'h0,        32'hCAFEF00D, 0, 2, 1, 0, 8,  32'h0);
`endif

    // Reset and reset-state checks.
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_strobes", {30'h0, sig_memread, sig_memwrite}, 32'h0);
    chk("rst_resp", {30'h0, resp_valid, resp_err}, 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_addr", mem_address, 32'h0);
    chk("rst_wdata", mem_write_data, 32'h0);
    chk("rst_state", 32'(dbg_state), 32'h0);

    // Directed table.
    for (int i = 0; i < NTBL; i++) begin
      run_vec(tbl[i], $sformatf("tbl%0d", i));
    end

    // Random requests checked against the reference model.
    for (int i = 0; i < NRAND; i++) begin
      ra = $urandom;
      rv.wr   = 1'($urandom_range(0, 1));
      rv.size = 2'($urandom_range(0, 3));
      rv.uns  = 1'($urandom_range(0, 1));
`ifdef MISALIGN_TRAP_EN
      if (rv.size == 2'b01) ra[0] = 1'b0;
      if (rv.size[1]) ra[1:0] = 2'b00;
`endif
      rv.addr    = ra;
      rv.wdata   = $urandom;
      old_w      = ref_mem[ra[6:2]];
      sub        = rv.wr && !rv.size[1];
      rv.exp_err = 1'b0;
      rv.exp_lat = sub ? 3 : 2;
      rv.exp_rd  = (!rv.wr || sub) ? 1 : 0;
      rv.exp_wr  = rv.wr ? 1 : 0;
      rv.exp_idx = {27'h0, ra[6:2]};
      rv.exp_rdata = rv.wr ? 32'h0 : model_load(old_w, rv.size, rv.uns, ra);
      rv.exp_wdata = model_merge(old_w, rv.size, ra, rv.wdata);
      run_vec(rv, $sformatf("rnd%0d", i));
    end

    // Reset asserted during the read phase of a byte store to word 10.
    @(negedge clk);
    req_write    = 1'b1;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 32'h28;
    req_wdata    = 32'h55;
    req_valid    = 1'b1;
    chk("abort_ready", 32'(req_ready), 32'd1);
    wr_cnt = 0;
    resp_before = resp_cnt;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_in_rd", {30'h0, sig_memread, sig_memwrite}, 32'h2);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("abort_ctl", {27'h0, req_ready, sig_memread, sig_memwrite, resp_valid, resp_err}, 32'h10);
    chk("abort_addr", mem_address, 32'h0);
    chk("abort_wdata", mem_write_data, 32'h0);
    chk("abort_rdata", resp_rdata, 32'h0);
    repeat (4) @(negedge clk);
    chk("abort_no_write", 32'(wr_cnt), 32'd0);
    chk("abort_no_resp", 32'(resp_cnt - resp_before), 32'd0);
    chk("abort_mem10", mem[10], ref_mem[10]);

    // Load held valid across the whole transaction: accepted exactly once.
    @(negedge clk);
    req_write    = 1'b0;
    req_size     = 2'b10;
    req_unsigned = 1'b0;
    req_addr     = 32'h1C;
    req_wdata    = 32'h0;
    req_valid    = 1'b1;
    acc_cnt = 0;
    rd_cnt  = 0;
    resp_before = resp_cnt;
    exp_q.push_back({1'b0, ref_mem[7]});
    lat_b = 0;
    @(posedge clk);
    @(negedge clk);
    lat_b = 1;
    while (!resp_valid && lat_b < 8) begin
      @(negedge clk);
      lat_b++;
    end
    if (!resp_valid) exp_q.delete();
    req_valid = 1'b0;
    chk("hold_latency", 32'(lat_b), 32'd2);
    repeat (4) @(negedge clk);
    chk("hold_accepts", 32'(acc_cnt), 32'd1);
    chk("hold_reads", 32'(rd_cnt), 32'd1);
    chk("hold_resps", 32'(resp_cnt - resp_before), 32'd1);

    // Final memory image and scoreboard drain.
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < NWORDS; i++) begin
      chk($sformatf("mem%0d", i), mem[i], ref_mem[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Load/store controller directly upstream of data_memory. Takes byte-addressed load/store requests from the datapath and converts them to word-indexed memory accesses. Supports byte, halfword and word sizes. Sub-word stores are done as read-modify-write. Loads are sign- or zero-extended. A valid/ready request and a one-cycle response pulse let the core stall while the access is in flight.

Parameters:
MEM_AW, 5, word-index width of data_memory (2^MEM_AW words; default 32).

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
req_valid  in  1  request present; held until accepted
req_ready  out  1  controller idle, request accepted this cycle if req_valid
req_write  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
req_unsigned  in  1  loads only: zero-extend instead of sign-extend
req_addr  in  32  byte address
req_wdata  in  32  store data, low bits used for sub-word
resp_valid  out  1  one-cycle pulse, access complete
resp_rdata  out  32  extended load data; 0 for stores
resp_err  out  1  misaligned access (see Optional Feature)
mem_address  out  32  word index {zeros, req_addr[MEM_AW+1:2]}
mem_write_data  out  32  merged store word
mem_read_data  in  32  combinational read data from memory
sig_memread  out  1  read strobe
sig_memwrite  out  1  write strobe

Behaviour:
- Reset values: req_ready=1; resp_valid=0, resp_rdata=0, resp_err=0; mem_address=0, mem_write_data=0; sig_memread=0, sig_memwrite=0; FSM=IDLE.
- All outputs are registered or decoded from state registers. No combinational path from req_* to mem_*.
- FSM states:
  - IDLE: req_ready=1. On req_valid, latch all req_* fields.
    - Load or sub-word store -> RD.
    - Word store -> WR.
  - RD: sig_memread=1, mem_address valid. mem_read_data is captured at the end of the cycle into data_q.
    - Load -> RESP.
    - Sub-word store -> WR.
  - WR: sig_memwrite=1 for exactly one cycle; mem_address and mem_write_data stable the whole cycle.
    - Word store: write_data = req_wdata.
    - Byte store: data_q with lane addr[1:0] replaced by wdata[7:0].
    - Half store: data_q with half addr[1] replaced by wdata[15:0].
    - Next state -> RESP.
  - RESP: resp_valid=1 for one cycle, then -> IDLE.
- req_ready=0 in RD/WR/RESP. The requester must hold req_valid and req_* stable. The next request is accepted no earlier than the cycle after RESP.
- Latency (cycles from the accept cycle to the resp_valid cycle):
  - Load: 2.
  - Word store: 2.
  - Sub-word store: 3.
- Load extraction is little-endian:
  - Byte: lane addr[1:0].
  - Half: bits [31:16] if addr[1]=1, else [15:0].
  - Sign-extended unless req_unsigned. Word loads ignore req_unsigned.
- Addresses above 2^(MEM_AW+2)-1 wrap: only index bits [MEM_AW+1:2] are used.
- mem_address and mem_write_data return to 0, and strobes deassert, whenever the FSM is in IDLE.
- Reset mid-operation: the FSM goes to IDLE at the reset edge. No strobe is asserted after that edge, and no response is produced for the aborted request. A WR cycle already completed before the edge stands.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: these requests are misaligned:
  - Half with addr[0]=1.
  - Word with addr[1:0]!=0.
  - Misaligned requests go IDLE -> RESP with resp_err=1 and resp_rdata=0; no strobe is issued.
- Undefined: misaligned addresses are aligned down (half clears bit 0, word clears bits [1:0]) and the access proceeds. resp_err is tied 0.

Test Plan:
- Memory preloaded mem[i]=i. LW addr 0x14 -> sig_memread pulse with mem_address=5; resp_valid 2 cycles after accept; resp_rdata=0x00000005.
- SB 0x80 to addr 0x09 -> RD word 2, then WR with mem_write_data=0x00008002; resp 3 cycles after accept. Then LB 0x09 -> 0xFFFFFF80, and LBU 0x09 -> 0x00000080.
- SH 0xBEEF to 0x0E -> word 3 becomes 0xBEEF0003. Then LH 0x0E -> 0xFFFFBEEF, and LHU 0x0E -> 0x0000BEEF.
- SW 0xDEADBEEF to 0x1C -> single sig_memwrite with no sig_memread; LW 0x1C -> 0xDEADBEEF. Address 0x9C wraps to word 7 and returns the same value.
- LW 0x06: with MISALIGN_TRAP_EN -> resp_err=1, no strobes, 1-cycle resp. Without it -> reads word 1, resp_rdata=0x00000001, resp_err=0.
- Assert reset during RD of an SB. Required: no sig_memwrite afterwards; req_ready=1 and all outputs 0 one cycle later; the memory word is unchanged. Also, req_valid held while busy must be accepted exactly once.
